// File: rtl/gp_cmd_decoder_if.sv
// gp_cmd_decoder_if: fetch-FIFO word stream in, decoded draw command out.
interface gp_cmd_decoder_if;
    logic        gp_valid;
    logic [31:0] fifo_word;
    logic        fifo_stall;
    logic        gp_stall;
    logic        gp_interrupt;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [1:0]  cmd_op;
    logic [23:0] cmd_color;
    logic [9:0]  cmd_x0;
    logic [9:0]  cmd_y0;
    logic [9:0]  cmd_x1;
    logic [9:0]  cmd_y1;

    modport master (
        output gp_valid, fifo_word, fifo_stall, cmd_ready,
        input  gp_stall, gp_interrupt, cmd_valid, cmd_op, cmd_color,
               cmd_x0, cmd_y0, cmd_x1, cmd_y1
    );

    modport slave (
        input  gp_valid, fifo_word, fifo_stall, cmd_ready,
        output gp_stall, gp_interrupt, cmd_valid, cmd_op, cmd_color,
               cmd_x0, cmd_y0, cmd_x1, cmd_y1
    );
endinterface

// File: rtl/gp_cmd_decoder.sv
// gp_cmd_decoder: decodes GP command lists (STOP/FILL/LINE) into draw commands.
// Define GP_CMD_STATS_EN to build the cmd_count/bad_op_count statistics counters.
module gp_cmd_decoder (
    input  logic              clk,
    input  logic              rst,
    gp_cmd_decoder_if.slave   bus,
    output logic              busy,
    output logic [15:0]       cmd_count,
    output logic [7:0]        bad_op_count
);
    typedef enum logic [2:0] {IDLE, PRIME, OPCODE, ARG1, ARG2, ISSUE, HALT} state_t;

    state_t      state, state_nx;
    logic [7:0]  opc;
    logic        take;

    assign opc = bus.fifo_word[31:24];
    // a word consumed under a simultaneous abort is thrown away
    assign take = (state inside {PRIME, OPCODE, ARG1, ARG2}) && !bus.fifo_stall && !bus.gp_valid;

    always_ff @(posedge clk)
        state <= rst ? IDLE : state_nx;

    always_comb begin
        state_nx = state;
        if (state == HALT)
            state_nx = bus.gp_valid ? PRIME : IDLE;
        else if (bus.gp_valid)
            state_nx = PRIME;
        else if (state == ISSUE)
            state_nx = bus.cmd_ready ? OPCODE : ISSUE;
        else if (take)
            state_nx = state == PRIME  ? OPCODE :
                       state == ARG1   ? ARG2   :
                       state == ARG2   ? ISSUE  :
                       opc == 8'h00    ? HALT   :
                       opc == 8'h01    ? ISSUE  :
                       opc == 8'h02    ? ARG1   : OPCODE;
    end

    always_comb begin
        bus.gp_stall     = state == ISSUE || state == HALT;
        bus.gp_interrupt = state == HALT;
        bus.cmd_valid    = state == ISSUE;
        busy             = state != IDLE;
    end

    // opcode low bits already encode cmd_op (01 FILL, 10 LINE)
    always_ff @(posedge clk) begin
        if (rst) begin
            bus.cmd_op    <= '0;
            bus.cmd_color <= '0;
            bus.cmd_x0    <= '0;
            bus.cmd_y0    <= '0;
            bus.cmd_x1    <= '0;
            bus.cmd_y1    <= '0;
        end else if (take) begin
            if (state == OPCODE && (opc == 8'h01 || opc == 8'h02)) begin
                bus.cmd_op    <= opc[1:0];
                bus.cmd_color <= bus.fifo_word[23:0];
            end
            if (state == ARG1) begin
                bus.cmd_x0 <= bus.fifo_word[25:16];
                bus.cmd_y0 <= bus.fifo_word[9:0];
            end
            if (state == ARG2) begin
                bus.cmd_x1 <= bus.fifo_word[25:16];
                bus.cmd_y1 <= bus.fifo_word[9:0];
            end
        end
    end

`ifdef GP_CMD_STATS_EN
    logic issue_done, bad_op;

    assign issue_done = state == ISSUE && bus.cmd_ready && !bus.gp_valid;
    assign bad_op     = take && state == OPCODE && opc > 8'h02;

    always_ff @(posedge clk) begin
        if (rst) begin
            cmd_count    <= '0;
            bad_op_count <= '0;
        end else begin
            if (issue_done && cmd_count != '1)
                cmd_count <= cmd_count + 16'd1;
            if (bad_op && bad_op_count != '1)
                bad_op_count <= bad_op_count + 8'd1;
        end
    end
`else
    assign cmd_count    = '0;
    assign bad_op_count = '0;
`endif
endmodule

// File: doc/gp_cmd_decoder.md
GP_CMD_DECODER -- requirements
Module: gp_cmd_decoder

Interface
REQ-001 SHALL have port clk, input, 1, system clock; all state changes on its rising edge.
REQ-002 SHALL have port rst, input, 1, synchronous active-high reset.
REQ-003 SHALL have port gp_valid, input, 1, one-cycle start pulse for a new command list.
REQ-004 SHALL have port fifo_word, input, 32, current command word from the GP fetch FIFO.
REQ-005 SHALL have port fifo_stall, input, 1, high when fifo_word is not yet valid.
REQ-006 SHALL have port gp_stall, output, 1, high when the decoder refuses the current word (FIFO holds its read pointer).
REQ-007 SHALL have port gp_interrupt, output, 1, one-cycle pulse on list termination.
REQ-008 SHALL have port cmd_valid, output, 1, decoded command present to the draw engine.
REQ-009 SHALL have port cmd_ready, input, 1, draw engine accepts the command.
REQ-010 SHALL have ports cmd_op (output, 2, 01 = FILL, 10 = LINE) and cmd_color (output, 24, RGB).
REQ-011 SHALL have ports cmd_x0, cmd_y0, cmd_x1 and cmd_y1, each output, 10, line endpoints.
REQ-012 SHALL have port busy, output, 1, high in any state other than IDLE.
REQ-013 SHALL have ports cmd_count (output, 16) and bad_op_count (output, 8), statistics counters (see Configuration).

Function
REQ-014 SHALL implement the states IDLE, PRIME, OPCODE, ARG1, ARG2, ISSUE and HALT.
REQ-015 SHALL define a word as consumed in a cycle when the state is PRIME, OPCODE, ARG1 or ARG2 and fifo_stall = 0.
REQ-016 SHALL drive gp_stall combinationally: 1 in ISSUE and HALT, 0 in all other states.
REQ-017 SHALL move IDLE -> PRIME on gp_valid.
REQ-018 SHALL discard the word consumed in PRIME (the FIFO's priming slot) and then move to OPCODE.
REQ-019 SHALL decode the opcode from word[31:24] when a word is consumed in OPCODE.
REQ-020 SHALL handle opcode 0x00 (STOP): move to HALT; in HALT, pulse gp_interrupt for exactly 1 cycle, then return to IDLE.
REQ-021 SHALL handle opcode 0x01 (FILL): latch cmd_color = word[23:0] and move to ISSUE.
REQ-022 SHALL handle opcode 0x02 (LINE): latch the colour and move to ARG1.
REQ-023 SHALL, in ARG1, latch x0 = word[25:16] and y0 = word[9:0], then move to ARG2.
REQ-024 SHALL, in ARG2, latch x1 = word[25:16] and y1 = word[9:0], then move to ISSUE.
REQ-025 SHALL treat any other opcode as a 1-word no-op: increment bad_op_count and remain in OPCODE.
REQ-026 SHALL hold cmd_valid = 1 and all cmd_* outputs stable throughout ISSUE.
REQ-027 SHALL leave ISSUE for OPCODE on cmd_valid & cmd_ready, incrementing cmd_count at that edge.
REQ-028 SHALL present cmd_valid no earlier than the cycle after the last argument word is consumed (minimum latency 1 cycle).
REQ-029 SHALL abort on gp_valid in any non-IDLE state: next state PRIME, cmd_valid dropped, no counter change, no gp_interrupt; gp_valid has priority over all other transitions.
REQ-030 SHALL ignore gp_valid and cmd_ready in HALT; on gp_valid in HALT, the interrupt pulse still completes and then the state goes to PRIME instead of IDLE.
REQ-031 SHALL saturate both counters at all-ones (no wrap-around).
REQ-032 SHALL keep cmd_x*/cmd_y* at their previous values on FILL commands.

Reset
REQ-033 SHALL, on rst, set state = IDLE and drive cmd_valid, gp_interrupt, busy and cmd_op to 0.
REQ-034 SHALL, on rst, clear cmd_color, all coordinates and both counters to 0.
REQ-035 SHALL have rst take priority over gp_valid and every handshake, including mid-ISSUE, where the command is dropped.

Configuration
REQ-036 SHALL, with GP_CMD_STATS_EN defined, implement cmd_count and bad_op_count as specified above.
REQ-037 SHALL, without GP_CMD_STATS_EN, tie cmd_count and bad_op_count to constant 0 with no counter registers; all other behaviour is identical.

Verification
REQ-038 SHALL cover: gp_valid, then words [junk, 0x01FF0000, 0x00000000], cmd_ready = 1 -> one FILL with cmd_color = 0xFF0000, cmd_count = 1, then a 1-cycle gp_interrupt and busy = 0.
REQ-039 SHALL cover: LINE words 0x0200FF00, 0x0005000A, 0x013F00EF -> cmd_op = 10, x0 = 5, y0 = 10, x1 = 319, y1 = 239.
REQ-040 SHALL cover: cmd_ready held low 20 cycles in ISSUE -> gp_stall = 1 and outputs stable for all 20 cycles, and exactly one cmd_count increment after release.
REQ-041 SHALL cover: fifo_stall high for 5 cycles during ARG1 -> no state advance and no coordinate change, with correct x0/y0 once fifo_stall drops.
REQ-042 SHALL cover: opcode 0x7F followed by STOP -> bad_op_count = 1, cmd_count = 0, gp_interrupt pulses.
REQ-043 SHALL cover: gp_valid asserted during ARG2, and rst asserted during ISSUE -> PRIME with cmd_valid = 0 in the first case, and IDLE with all outputs 0 in the second.
